// File: rtl/mux_gate_pkg.sv
// Shared types for the mux-built gate sequencer.
//   op_e        : 3-bit gate opcode; encoding 7 is reserved and treated as illegal
//   state_e     : sequencer FSM states
//   num_passes  : mux passes needed per result bit (0 for an illegal op)
//   op_legal    : true for the seven implemented gate ops
package mux_gate_pkg;

    typedef enum logic [2:0] {
        OpAnd  = 3'd0,
        OpOr   = 3'd1,
        OpNot  = 3'd2,
        OpNand = 3'd3,
        OpNor  = 3'd4,
        OpXor  = 3'd5,
        OpXnor = 3'd6,
        OpRsvd = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEval = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [1:0] num_passes(input op_e op);
        logic [1:0] p;
        case (op)
            OpAnd, OpOr, OpNot:          p = 2'd1;
            OpNand, OpNor, OpXor, OpXnor: p = 2'd2;
            default:                     p = 2'd0;
        endcase
        return p;
    endfunction

    function automatic logic op_legal(input op_e op);
        return op != OpRsvd;
    endfunction

endpackage

// File: rtl/mux2_cell.sv
// Single 2:1 mux cell; every gate evaluation in the sequencer is built from it.
//   sel_i : select (1 -> d1_i, 0 -> d0_i)
//   d0_i  : data input chosen when sel_i = 0
//   d1_i  : data input chosen when sel_i = 1
//   y_o   : mux output
module mux2_cell (
    input  logic sel_i,
    input  logic d0_i,
    input  logic d1_i,
    output logic y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_gate_sequencer.sv
// Bit-serial gate unit: evaluates one of seven bitwise ops on WIDTH-bit operands, LSB first,
// through a single shared mux2_cell. Two-level ops use two mux passes per bit, with the first
// pass held in a one-bit temporary.
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   in_valid_i    : request valid; accepted with in_ready_o at a rising edge
//   in_ready_o    : high only in the idle state
//   in_op_i       : op_e opcode (7 is illegal)
//   in_a_i/in_b_i : operands, latched on accept (in_b_i unused for NOT)
//   out_valid_o   : result valid, held until out_ready_i
//   out_ready_i   : sink accept
//   out_result_o  : result, stable while out_valid_o
//   out_err_o     : illegal-op flag, stable while out_valid_o
//   busy_o        : high while evaluating
//   eval_cnt_o    : mux evaluations used by the current/last op, saturating at 2*WIDTH
module mux_gate_sequencer
    import mux_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [2:0]                     in_op_i,
    input  logic [WIDTH-1:0]               in_a_i,
    input  logic [WIDTH-1:0]               in_b_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [WIDTH-1:0]               out_result_o,
    output logic                           out_err_o,
    output logic                           busy_o,
    output logic [$clog2(2*WIDTH+1)-1:0]   eval_cnt_o
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(2*WIDTH+1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * WIDTH);

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [BIT_W-1:0]   bit_q;
    logic               pass_q;
    logic               t_q;
    logic [WIDTH-1:0]   result_q;
    logic               err_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               a_bit;
    logic               b_bit;
    logic               mux_sel;
    logic               mux_d0;
    logic               mux_d1;
    logic               mux_y;
    logic               last_pass;
    op_e                in_op;

    assign in_op = op_e'(in_op_i);
    assign a_bit = a_q[bit_q];
    assign b_bit = b_q[bit_q];

    // Final pass of a bit is pass P-1; only that pass writes the result.
    assign last_pass = ({1'b0, pass_q} == (num_passes(op_q) - 2'd1));

    // Route the operands of the current (op, pass) onto the shared mux.
    always_comb begin
        mux_sel = 1'b0;
        mux_d1  = 1'b0;
        mux_d0  = 1'b0;
        unique case (op_q)
            OpAnd:   {mux_sel, mux_d1, mux_d0} = {b_bit, a_bit, 1'b0};
            OpOr:    {mux_sel, mux_d1, mux_d0} = {a_bit, 1'b1, b_bit};
            OpNot:   {mux_sel, mux_d1, mux_d0} = {a_bit, 1'b0, 1'b1};
            OpNand:  {mux_sel, mux_d1, mux_d0} = pass_q ? {t_q, 1'b0, 1'b1}
                                                        : {b_bit, a_bit, 1'b0};
            OpNor:   {mux_sel, mux_d1, mux_d0} = pass_q ? {t_q, 1'b0, 1'b1}
                                                        : {a_bit, 1'b1, b_bit};
            // First pass of XOR/XNOR forms ~a in t; second pass picks between a and ~a on b.
            OpXor:   {mux_sel, mux_d1, mux_d0} = pass_q ? {b_bit, t_q, a_bit}
                                                        : {a_bit, 1'b0, 1'b1};
            OpXnor:  {mux_sel, mux_d1, mux_d0} = pass_q ? {b_bit, a_bit, t_q}
                                                        : {a_bit, 1'b0, 1'b1};
            default: {mux_sel, mux_d1, mux_d0} = 3'b000;
        endcase
    end

    mux2_cell u_mux (
        .sel_i (mux_sel),
        .d0_i  (mux_d0),
        .d1_i  (mux_d1),
        .y_o   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpAnd;
            a_q      <= '0;
            b_q      <= '0;
            bit_q    <= '0;
            pass_q   <= 1'b0;
            t_q      <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        op_q     <= in_op;
                        a_q      <= in_a_i;
                        b_q      <= in_b_i;
                        bit_q    <= '0;
                        pass_q   <= 1'b0;
                        t_q      <= 1'b0;
                        result_q <= '0;
                        cnt_q    <= '0;
                        if (op_legal(in_op)) begin
                            err_q   <= 1'b0;
                            state_q <= StEval;
                        end else begin
                            // Illegal op skips evaluation; valid is raised one cycle later.
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StEval: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (last_pass) begin
                        result_q[bit_q] <= mux_y;
                        pass_q          <= 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_q <= StDone;
                            valid_q <= 1'b1;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        t_q    <= mux_y;
                        pass_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (out_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o   = (state_q == StIdle);
    assign busy_o       = (state_q == StEval);
    assign out_valid_o  = valid_q;
    assign out_result_o = result_q;
    assign out_err_o    = err_q;
    assign eval_cnt_o   = cnt_q;

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Bench for mux_gate_sequencer (WIDTH=8): directed scenarios plus randomized ops, each checked
// against a plain bitwise reference model.
module tb_mux_gate_sequencer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_err;
    logic         busy;
    logic [4:0]   eval_cnt;

    int n_checks;
    int n_fail;

    mux_gate_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_op_i      (in_op),
        .in_a_i       (in_a),
        .in_b_i       (in_b),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_result_o (out_result),
        .out_err_o    (out_err),
        .busy_o       (busy),
        .eval_cnt_o   (eval_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic int passes(input logic [2:0] op);
        return (op <= 3'd2) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for the result, hold the sink off, then hand over.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic         exp_err;
        logic [W-1:0] exp_res;
        int           exp_lat;
        int           exp_cnt;
        int           lat;
        exp_err = (op == 3'd7);
        exp_res = exp_err ? '0 : model(op, a, b);
        exp_lat = exp_err ? 1 : passes(op) * W;
        exp_cnt = exp_err ? 0 : passes(op) * W;

        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        // Keep in_valid high with scrambled inputs: must be ignored while busy.
        in_op = 3'($urandom);
        in_a  = W'($urandom);
        in_b  = W'($urandom);
        check("busy_after_accept", {31'd0, busy}, {31'd0, ~exp_err});
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", {24'd0, out_result}, {24'd0, exp_res});
        check("err", {31'd0, out_err}, {31'd0, exp_err});
        check("eval_cnt", {27'd0, eval_cnt}, exp_cnt);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", {24'd0, out_result}, {24'd0, exp_res});
            check("hold_err", {31'd0, out_err}, {31'd0, exp_err});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, out_result}, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_eval_cnt", {27'd0, eval_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(3'd0, 8'hF0, 8'h3C, 0);
        run_op(3'd5, 8'hA5, 8'hFF, 1);
        run_op(3'd6, 8'hA5, 8'h0F, 0);
        run_op(3'd2, 8'h0F, 8'h99, 2);
        run_op(3'd4, 8'h00, 8'h00, 0);
        run_op(3'd3, 8'hFF, 8'hFF, 0);
        run_op(3'd7, 8'h12, 8'h34, 0);
        // Sink stalls 5 cycles, then a back-to-back op
        run_op(3'd1, 8'h81, 8'h42, 5);
        run_op(3'd5, 8'h3C, 8'h0F, 0);

        // Reset in the middle of a NAND (bit 3)
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd3;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", {24'd0, out_result}, 32'd0);
        check("midrst_err", {31'd0, out_err}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_eval_cnt", {27'd0, eval_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_hold_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd1, 8'h0C, 8'h30, 0);

        // Randomized ops, including the illegal opcode
        for (int k = 0; k < 24; k++) begin
            run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
